serial_parity_checker: RTL and testbench
========================================

// Module: serial_parity_checker
// PURPOSE
//  Serial receiver downstream of the 3-bit parity generator. Frame: start(0), DATA_W data bits LSB first, parity, stop(1).
//  Deserialises the frame, recomputes parity, and flags parity/framing errors. Presents the word with a 1-cycle valid pulse.
//  Sits between the serial link and the parallel consumer; one bit is accepted per bit_vld strobe.
// PARAMETERS
//  DATA_W   3   data bits per frame (>=1)
//  ODD      0   0: even parity (parity bit = XOR of data); 1: odd parity (parity bit = ~XOR of data)
// PORTS
//  clk         in   1        system clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  bit_vld     in   1        strobe: bit_in is sampled on this edge when high
//  bit_in      in   1        serial line bit
//  data_out    out  DATA_W   last received data word (held until next frame completes)
//  data_vld    out  1        one-cycle pulse: data_out/parity_err/frame_err updated
//  parity_err  out  1        1 = received parity bit mismatched (held with data_out)
//  frame_err   out  1        1 = stop bit sampled as 0 (held with data_out)
//  busy        out  1        1 while state != IDLE
//  err_cnt     out  8        saturating count of errored frames (only with SPC_ERR_CNT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, bit counter=0, shift reg=0, running parity=0; all outputs 0.
//  - All state changes occur only on edges with bit_vld=1; with bit_vld=0 state and registers hold.
//  - FSM: IDLE -> DATA -> PAR -> STOP -> IDLE.
//    IDLE: bit_in=0 starts a frame (cnt<=0, par<=0) -> DATA; bit_in=1 is line idle, ignored.
//    DATA: shift bit_in into MSB of shift reg (LSB-first arrival), par<=par^bit_in, cnt++; after DATA_W-th bit -> PAR.
//    PAR : perr<= (bit_in != (par ^ ODD)) -> STOP.
//    STOP: on the sampling edge register data_out<=shift reg, parity_err<=perr, frame_err<=~bit_in,
//          data_vld<=1 -> IDLE. data_vld drops to 0 on the next edge regardless of bit_vld.
//  - Latency: data_vld high in the cycle immediately after the edge that samples the stop bit.
//  - Errored frames still deliver data_out and data_vld; errors are flags, not drops.
//  - Stop bit 0 (frame_err): return to IDLE anyway; no resync hunting. A following 0 is treated as a new start bit.
//  - Back-to-back frames: a start bit may be presented on the strobe right after the stop bit; no idle bit required.
//  - Counter width: $clog2(DATA_W+1); cnt never exceeds DATA_W.
//  - busy=1 from the edge sampling the start bit until the edge sampling the stop bit.
//  - Reset mid-frame: partial frame discarded, no data_vld, outputs 0.
// CONFIGURATION
//  SPC_ERR_CNT_EN defined: err_cnt increments on every data_vld with (parity_err|frame_err).
//    It saturates at 8'hFF and is cleared only by rst_n.
//  SPC_ERR_CNT_EN undefined: err_cnt port and counter logic are absent.
// TESTING
//  1 ODD=0, frame 0,1,0,1,0,1 (start, data 101, par 0, stop) -> data_out=3'b101, parity_err=0, frame_err=0, one data_vld pulse.
//  2 ODD=0, frame 0,1,1,0,1,1 (data 011, par 1 wrong) -> data_out=3'b011, parity_err=1; err_cnt=1 if enabled.
//  3 Stop bit 0: frame 0,0,0,0,0,0 -> data_out=0, frame_err=1, parity_err=0; FSM back in IDLE.
//  4 bit_vld gaps of 0-5 random cycles between bits of frame 1 -> identical result, exactly one data_vld.
//  5 rst_n low for 1 cycle after two data bits, then full frame 1 -> no pulse before reset; frame 1 output after.
//  6 ODD=1, data 111, par 0 -> parity_err=0; 300 bad frames with SPC_ERR_CNT_EN -> err_cnt=8'hFF.

Source files
------------

// File: rtl/serial_parity_checker.sv
// serial_parity_checker
// Serial frame receiver. A frame is a start bit (0), DATA_W data bits sent
// LSB first, one parity bit and a stop bit (1). The receiver rebuilds the
// word, recomputes the parity and flags parity and framing errors. The
// result is shown on data_out together with a one-cycle data_vld pulse.
// The FSM and the datapath only advance on clock edges where bit_vld is high.
//
// Optional feature: define SPC_ERR_CNT_EN to add err_cnt. This is an 8-bit
// saturating count of frames that had a parity error or a framing error.
module serial_parity_checker #(
    parameter int DATA_W = 3,
    parameter int ODD    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_vld,
    input  logic              bit_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
`ifdef SPC_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int   CNT_W   = $clog2(DATA_W + 1);
    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        STOP = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              par_reg;
    logic              perr_reg;
    logic              last_data_bit;

    assign last_data_bit = (cnt_reg == CNT_W'(DATA_W - 1));

    // Data arrives LSB first, so each new bit enters at the MSB. After DATA_W
    // shifts, the first bit received has reached bit 0.
    generate
        if (DATA_W == 1) begin : g_shift_single
            assign shift_next = bit_in;
        end else begin : g_shift_multi
            assign shift_next = {bit_in, shift_reg[DATA_W-1:1]};
        end
    endgenerate

    // State register. It only advances on edges where a bit is strobed in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else if (bit_vld) begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A stop bit of 0 still returns to IDLE, with no resync.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (!bit_in) state_next = DATA;
            DATA:    if (last_data_bit) state_next = PAR;
            PAR:     state_next = STOP;
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic that comes straight from the state.
    always_comb begin
        busy = (state_reg != IDLE);
    end

    // Datapath. This block holds the bit counter, the shift register and the
    // running parity, and checks the parity bit when it arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
            par_reg   <= 1'b0;
            perr_reg  <= 1'b0;
        end else if (bit_vld) begin
            case (state_reg)
                IDLE: begin
                    if (!bit_in) begin
                        cnt_reg <= '0;
                        par_reg <= 1'b0;
                    end
                end
                DATA: begin
                    shift_reg <= shift_next;
                    par_reg   <= par_reg ^ bit_in;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                end
                PAR: begin
                    perr_reg <= (bit_in != (par_reg ^ ODD_BIT));
                end
                default: ;
            endcase
        end
    end

    // Result registers. They load when the stop bit is sampled and then hold
    // until the next frame completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else if (bit_vld && (state_reg == STOP)) begin
            data_out   <= shift_reg;
            parity_err <= perr_reg;
            frame_err  <= ~bit_in;
        end
    end

    // Valid pulse. It lasts exactly one cycle, whether or not the next edge
    // has a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_vld <= 1'b0;
        end else begin
            data_vld <= bit_vld && (state_reg == STOP);
        end
    end

`ifdef SPC_ERR_CNT_EN
    // Errored-frame counter. It counts on the valid pulse and sticks at 8'hFF.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'h00;
        end else if (data_vld && (parity_err || frame_err) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker. It uses two instances: even parity (u_even)
// and odd parity (u_odd). When a frame is sent, its hand-computed result is
// queued. A monitor on each instance takes one entry off its queue for every
// data_vld pulse.
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       vld0, bin0, vld1, bin1;
    logic [2:0] dout0, dout1;
    logic       dv0, dv1, pe0, pe1, fe0, fe1, busy0, busy1;
`ifdef SPC_ERR_CNT_EN
    logic [7:0] ecnt0, ecnt1;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_W(3), .ODD(0)) u_even (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_vld    (vld0),
        .bit_in     (bin0),
        .data_out   (dout0),
        .data_vld   (dv0),
        .parity_err (pe0),
        .frame_err  (fe0),
        .busy       (busy0)
`ifdef SPC_ERR_CNT_EN
        ,
        .err_cnt    (ecnt0)
`endif
    );

    serial_parity_checker #(.DATA_W(3), .ODD(1)) u_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_vld    (vld1),
        .bit_in     (bin1),
        .data_out   (dout1),
        .data_vld   (dv1),
        .parity_err (pe1),
        .frame_err  (fe1),
        .busy       (busy1)
`ifdef SPC_ERR_CNT_EN
        ,
        .err_cnt    (ecnt1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the even-parity instance. Each pulse is checked against the
    // next queued expectation.
    always @(negedge clk) begin
        if (rst_n && dv0) begin
            if (q0.size() == 0) begin
                check("even_unexpected_vld", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("even_data", {29'd0, dout0}, {29'd0, e.d});
                check("even_perr", {31'd0, pe0}, {31'd0, e.pe});
                check("even_ferr", {31'd0, fe0}, {31'd0, e.fe});
                $display("even frame: data=%b perr=%b ferr=%b", dout0, pe0, fe0);
            end
        end
    end

    // Monitor for the odd-parity instance.
    always @(negedge clk) begin
        if (rst_n && dv1) begin
            if (q1.size() == 0) begin
                check("odd_unexpected_vld", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("odd_data", {29'd0, dout1}, {29'd0, e.d});
                check("odd_perr", {31'd0, pe1}, {31'd0, e.pe});
                check("odd_ferr", {31'd0, fe1}, {31'd0, e.fe});
                $display("odd frame: data=%b perr=%b ferr=%b", dout1, pe1, fe1);
            end
        end
    end

    // Strobe one bit into one instance, then wait for `gap` idle cycles.
    // The caller enters this task 1 time unit after a rising edge.
    task automatic send_bit(input bit sel, input logic b, input int gap);
        if (sel) begin
            vld1 = 1'b1;
            bin1 = b;
        end else begin
            vld0 = 1'b1;
            bin0 = b;
        end
        @(posedge clk);
        #1;
        vld0 = 1'b0;
        vld1 = 1'b0;
        bin0 = 1'b1;
        bin1 = 1'b1;
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame: start, d[0], d[1], d[2], parity p, stop s. Each gap is
    // chosen at random from 0..maxgap. The expected result is given by the caller.
    task automatic send_frame(input bit sel, input logic [2:0] d, input logic p, input logic s,
                              input int maxgap, input logic [2:0] ed, input logic epe,
                              input logic efe);
        exp_t e;
        e.d  = ed;
        e.pe = epe;
        e.fe = efe;
        if (sel) q1.push_back(e);
        else     q0.push_back(e);
        send_bit(sel, 1'b0, $urandom_range(0, maxgap));
        check("busy_after_start", {31'd0, (sel ? busy1 : busy0)}, 32'd1);
        for (int i = 0; i < 3; i++) send_bit(sel, d[i], $urandom_range(0, maxgap));
        send_bit(sel, p, $urandom_range(0, maxgap));
        send_bit(sel, s, 0);
        check("busy_after_stop", {31'd0, (sel ? busy1 : busy0)}, 32'd0);
        for (int i = 0; i < int'($urandom_range(0, maxgap)); i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vld0 = 1'b0; bin0 = 1'b1;
        vld1 = 1'b0; bin1 = 1'b1;
        wait_cycles(3);

        // Reset state.
        check("rst_data",  {29'd0, dout0}, 32'd0);
        check("rst_vld",   {31'd0, dv0},   32'd0);
        check("rst_perr",  {31'd0, pe0},   32'd0);
        check("rst_ferr",  {31'd0, fe0},   32'd0);
        check("rst_busy",  {31'd0, busy0}, 32'd0);
`ifdef SPC_ERR_CNT_EN
        check("rst_errcnt", {24'd0, ecnt0}, 32'd0);
`endif
        rst_n = 1'b1;
        wait_cycles(1);

        // Idle-line 1s are ignored.
        send_bit(1'b0, 1'b1, 0);
        send_bit(1'b0, 1'b1, 1);
        check("idle_ones_busy", {31'd0, busy0}, 32'd0);

        // 1: data 101, even parity 0, good stop.
        send_frame(1'b0, 3'b101, 1'b0, 1'b1, 0, 3'b101, 1'b0, 1'b0);
        // 2: data 011 with a wrong parity bit (1).
        send_frame(1'b0, 3'b011, 1'b1, 1'b1, 0, 3'b011, 1'b1, 1'b0);
        wait_cycles(2);
`ifdef SPC_ERR_CNT_EN
        check("errcnt_after_perr", {24'd0, ecnt0}, 32'd1);
`endif
        // 3: all zeros, so the stop bit is 0 (framing error).
        send_frame(1'b0, 3'b000, 1'b0, 1'b0, 0, 3'b000, 1'b0, 1'b1);
        // Back-to-back: a start bit on the very next strobe after the bad stop.
        send_frame(1'b0, 3'b110, 1'b0, 1'b1, 0, 3'b110, 1'b0, 1'b0);
        wait_cycles(2);
`ifdef SPC_ERR_CNT_EN
        check("errcnt_after_ferr", {24'd0, ecnt0}, 32'd2);
`endif
        check("hold_data", {29'd0, dout0}, 32'd6);
        check("vld_dropped", {31'd0, dv0}, 32'd0);

        // 4: frame 1 again, with random gaps of 0-5 cycles.
        for (int k = 0; k < 3; k++)
            send_frame(1'b0, 3'b101, 1'b0, 1'b1, 5, 3'b101, 1'b0, 1'b0);

        // 5: reset after the start bit and two data bits.
        send_bit(1'b0, 1'b0, 0);
        send_bit(1'b0, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy0}, 32'd0);
        check("midrst_data", {29'd0, dout0}, 32'd0);
`ifdef SPC_ERR_CNT_EN
        check("midrst_errcnt", {24'd0, ecnt0}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(1);
        send_frame(1'b0, 3'b101, 1'b0, 1'b1, 0, 3'b101, 1'b0, 1'b0);

        // 6: odd parity. Data 111 with parity 0 is correct; parity 1 is wrong.
        send_frame(1'b1, 3'b111, 1'b0, 1'b1, 0, 3'b111, 1'b0, 1'b0);
        send_frame(1'b1, 3'b100, 1'b0, 1'b1, 2, 3'b100, 1'b0, 1'b0);
        send_frame(1'b1, 3'b111, 1'b1, 1'b1, 0, 3'b111, 1'b1, 1'b0);

        // 300 bad frames on the even instance. The counter must saturate.
        for (int k = 0; k < 300; k++) begin
            if (k[0]) send_frame(1'b0, 3'b001, 1'b0, 1'b1, 0, 3'b001, 1'b1, 1'b0);
            else      send_frame(1'b0, 3'b000, 1'b0, 1'b0, 0, 3'b000, 1'b0, 1'b1);
        end
        wait_cycles(3);
`ifdef SPC_ERR_CNT_EN
        check("errcnt_saturated", {24'd0, ecnt0}, 32'hFF);
        check("odd_errcnt", {24'd0, ecnt1}, 32'd1);
`endif

        // Drain: every queued expectation must have been consumed.
        for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) wait_cycles(1);
        check("even_queue_empty", q0.size(), 32'd0);
        check("odd_queue_empty", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
